// File: rtl/gate_vector_checker.sv
// gate_vector_checker
//   Self-test sequencer and checker for the 2-input gate bank. Steps {a,b} through
//   00,01,10,11 for LOOPS passes and holds each vector for HOLD_CYCLES clocks. On the
//   last hold cycle of each vector it compares gate_out against the expected gate values.
//   It reports a saturating error count, a sticky mismatch mask and pass/done status.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   start     begin a run (only looked at in IDLE)
//   gate_out  gate bank outputs: [7]and [6]or [5]nand [4]nota [3]notb [2]nor [1]xor [0]xnor
//   a, b      registered stimulus to the gate bank
//   busy      high while the vector sequence is running
//   done      single-cycle pulse at the end of a run
//   pass      set when a run ends with err_cnt==0, held until the next start
//   err_cnt   count of sampled vectors with at least one mismatching bit (saturating)
//   err_vec   sticky OR of (gate_out ^ expected) over the run
//
// Optional feature (macro GATE_CHK_FIRST_FAIL_EN)
//   Adds first_fail_vld / first_fail_ab / first_fail_out, which capture the first
//   mismatching sample of a run and then freeze until the next accepted start.
//
// State | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; results of the previous run readable
// RUN   | driving vectors, sampling at the end of each hold
// DONE  | one cycle: done pulse, pass valid
module gate_vector_checker #(
    parameter int HOLD_CYCLES = 2,
    parameter int LOOPS       = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       gate_out,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       err_vec
`ifdef GATE_CHK_FIRST_FAIL_EN
    ,
    output logic             first_fail_vld,
    output logic [1:0]       first_fail_ab,
    output logic [7:0]       first_fail_out
`endif
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        vec;
    logic [LOOP_W-1:0] loop_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic [7:0]        expected;
    logic [7:0]        mismatch;
    logic              sample;
    logic              any_fail;
    logic              last_sample;
    logic [CNT_W-1:0]  err_cnt_nxt;

    assign expected    = {a & b, a | b, ~(a & b), ~a, ~b, ~(a | b), a ^ b, ~(a ^ b)};
    assign mismatch    = gate_out ^ expected;
    // hold_cnt is a down-counter; reaching zero marks the last hold cycle of a vector
    assign sample      = (state == ST_RUN) && (hold_cnt == '0);
    assign any_fail    = sample && (mismatch != 8'h00);
    assign last_sample = sample && (vec == 2'd3) && (loop_cnt == LOOP_LAST);
    assign err_cnt_nxt = (any_fail && (err_cnt != '1)) ? err_cnt + CNT_W'(1) : err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            vec      <= 2'd0;
            loop_cnt <= '0;
            hold_cnt <= '0;
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            err_vec  <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        busy     <= 1'b1;
                        pass     <= 1'b0;
                        err_cnt  <= '0;
                        err_vec  <= 8'h00;
                        vec      <= 2'd0;
                        loop_cnt <= '0;
                        hold_cnt <= HOLD_LOAD;
                        a        <= 1'b0;
                        b        <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (sample) begin
                        err_cnt  <= err_cnt_nxt;
                        err_vec  <= err_vec | mismatch;
                        hold_cnt <= HOLD_LOAD;
                        vec      <= vec + 2'd1;
                        {a, b}   <= vec + 2'd1;
                        if (vec == 2'd3) begin
                            loop_cnt <= loop_cnt + LOOP_W'(1);
                        end
                        if (last_sample) begin
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            // err_cnt_nxt already includes the final sample
                            pass     <= (err_cnt_nxt == '0);
                            loop_cnt <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    a     <= 1'b0;
                    b     <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef GATE_CHK_FIRST_FAIL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_fail_vld <= 1'b0;
            first_fail_ab  <= 2'b00;
            first_fail_out <= 8'h00;
        end else if ((state == ST_IDLE) && start) begin
            first_fail_vld <= 1'b0;
            first_fail_ab  <= 2'b00;
            first_fail_out <= 8'h00;
        end else if (any_fail && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_ab  <= {a, b};
            first_fail_out <= gate_out;
        end
    end
`endif

endmodule
